// File: rtl/bht_2bit_table.sv
// Pattern history table of 2-bit counters with IF/ID and ID/EX carry registers
// so the EX-stage update logic sees the state the branch was predicted with.
module bht_2bit_table #(
   parameter int unsigned INDEX_BITS = 4,
   parameter int unsigned PC_W       = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PC_W-1:0]       pc_if,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  upd_en,
   input  logic [1:0]            entry_in,
   output logic [1:0]            state_if,
   output logic                  pred_taken_if,
   output logic [1:0]            state_id_ex,
   output logic [INDEX_BITS-1:0] idx_ex,
   output logic                  valid_ex
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;

   logic [1:0]            pht [ENTRIES];
   logic [INDEX_BITS-1:0] idx_if;
   logic                  wr_en;
   logic                  v_id;
   logic [INDEX_BITS-1:0] idx_id;
   logic [1:0]            st_id;
   logic                  unused_pc_bits;

   assign idx_if         = pc_if[INDEX_BITS+1:2];
   assign unused_pc_bits = ^{pc_if[PC_W-1:INDEX_BITS+2], pc_if[1:0]};
   assign wr_en          = upd_en && valid_ex;

   // Write-first bypass: IF sees the counter EX is committing this cycle.
   always_comb begin
      state_if = pht[idx_if];
      if (wr_en && (idx_ex == idx_if)) begin
         state_if = entry_in;
      end
   end

   assign pred_taken_if = state_if[1];

   // The EX branch is older than any flush, so the write is never suppressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            pht[i] <= 2'b01;
         end
      end else if (wr_en) begin
         pht[idx_ex] <= entry_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_id   <= 1'b0;
         idx_id <= '0;
         st_id  <= 2'b01;
      end else if (flush) begin
         v_id <= 1'b0;
      end else if (!stall) begin
         v_id   <= 1'b1;
         idx_id <= idx_if;
         st_id  <= state_if;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_ex    <= 1'b0;
         idx_ex      <= '0;
         state_id_ex <= 2'b01;
      end else if (flush) begin
         valid_ex <= 1'b0;
      end else if (!stall) begin
         valid_ex    <= v_id;
         idx_ex      <= idx_id;
         state_id_ex <= st_id;
      end
   end

endmodule

// File: tb/tb_bht_2bit_table.sv
// Directed checks of the branch history table: reset, pipeline carry, bypass,
// flush/stall priority, stall idempotence, index aliasing and async reset.
module tb_bht_2bit_table;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_if;
   logic        stall;
   logic        flush;
   logic        upd_en;
   logic [1:0]  entry_in;
   logic [1:0]  state_if;
   logic        pred_taken_if;
   logic [1:0]  state_id_ex;
   logic [3:0]  idx_ex;
   logic        valid_ex;

   int vectors    = 0;
   int miscompares = 0;

   bht_2bit_table #(.INDEX_BITS(4), .PC_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_if         (pc_if),
      .stall         (stall),
      .flush         (flush),
      .upd_en        (upd_en),
      .entry_in      (entry_in),
      .state_if      (state_if),
      .pred_taken_if (pred_taken_if),
      .state_id_ex   (state_id_ex),
      .idx_ex        (idx_ex),
      .valid_ex      (valid_ex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; pc_if = '0; stall = 1'b0; flush = 1'b0; upd_en = 1'b0; entry_in = 2'b00;
      #12;
      rst_n = 1'b1;
      #1;
      chk("rst_valid_ex", {31'b0, valid_ex}, 32'd0);
      chk("rst_state_id_ex", {30'b0, state_id_ex}, 32'd1);
      chk("rst_idx_ex", {28'b0, idx_ex}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         pc_if = i * 4;
         #1;
         chk($sformatf("rst_read_%0d", i), {30'b0, state_if}, 32'd1);
         chk($sformatf("rst_pred_%0d", i), {31'b0, pred_taken_if}, 32'd0);
      end

      // drain the pipeline to a known empty state
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_clear", {31'b0, valid_ex}, 32'd0);

      // pipeline flow: pc 0x10 -> idx 4
      pc_if = 32'h10;
      tick();
      chk("flow_e1_valid", {31'b0, valid_ex}, 32'd0);
      tick();
      chk("flow_valid", {31'b0, valid_ex}, 32'd1);
      chk("flow_idx", {28'b0, idx_ex}, 32'd4);
      chk("flow_state", {30'b0, state_id_ex}, 32'd1);

      // update with same-cycle bypass
      upd_en = 1'b1; entry_in = 2'd2;
      #1;
      chk("bypass_state", {30'b0, state_if}, 32'd2);
      chk("bypass_pred", {31'b0, pred_taken_if}, 32'd1);
      tick();
      upd_en = 1'b0;
      #1;
      chk("array_state", {30'b0, state_if}, 32'd2);
      chk("array_pred", {31'b0, pred_taken_if}, 32'd1);
      chk("stale_ex_state", {30'b0, state_id_ex}, 32'd1);
      tick();
      chk("bypassed_carry", {30'b0, state_id_ex}, 32'd2);

      // flush beats stall; the EX write still lands
      pc_if = 32'h20;
      flush = 1'b1; stall = 1'b1; upd_en = 1'b1; entry_in = 2'd3;
      tick();
      flush = 1'b0; stall = 1'b0; upd_en = 1'b0;
      #1;
      chk("fs_valid_ex", {31'b0, valid_ex}, 32'd0);
      pc_if = 32'h10;
      #1;
      chk("fs_write", {30'b0, state_if}, 32'd3);
      tick();
      chk("fs_vid_clear", {31'b0, valid_ex}, 32'd0);

      // set table[5]=0 and bring a state-0 branch to EX
      pc_if = 32'h14;
      tick();
      tick();
      upd_en = 1'b1; entry_in = 2'd0;
      tick();
      upd_en = 1'b0;
      tick();
      chk("pre_stall_state", {30'b0, state_id_ex}, 32'd0);
      chk("pre_stall_idx", {28'b0, idx_ex}, 32'd5);

      // stall for 3 cycles with a held update
      stall = 1'b1; upd_en = 1'b1; entry_in = 2'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("stall_valid_%0d", i), {31'b0, valid_ex}, 32'd1);
         chk($sformatf("stall_idx_%0d", i), {28'b0, idx_ex}, 32'd5);
         chk($sformatf("stall_state_%0d", i), {30'b0, state_id_ex}, 32'd0);
      end
      stall = 1'b0; upd_en = 1'b0;
      #1;
      chk("stall_table", {30'b0, state_if}, 32'd1);
      tick();
      chk("stall_id_held", {30'b0, state_id_ex}, 32'd0);

      // aliasing: idx 2 reached from 0x08, 0x48, 0x88
      pc_if = 32'h08;
      tick();
      tick();
      chk("alias_idx_ex", {28'b0, idx_ex}, 32'd2);
      upd_en = 1'b1; entry_in = 2'd3;
      tick();
      upd_en = 1'b0;
      #1;
      chk("alias_08", {30'b0, state_if}, 32'd3);
      pc_if = 32'h48;
      #1;
      chk("alias_48", {30'b0, state_if}, 32'd3);
      chk("alias_48_pred", {31'b0, pred_taken_if}, 32'd1);
      pc_if = 32'h88;
      #1;
      chk("alias_88", {30'b0, state_if}, 32'd3);
      pc_if = 32'h0C;
      #1;
      chk("neighbour_0c", {30'b0, state_if}, 32'd1);

      // async reset between edges
      tick();
      chk("pre_rst_valid", {31'b0, valid_ex}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'b0, valid_ex}, 32'd0);
      chk("arst_state", {30'b0, state_id_ex}, 32'd1);
      chk("arst_idx", {28'b0, idx_ex}, 32'd0);
      pc_if = 32'h48;
      #1;
      chk("arst_tbl_48", {30'b0, state_if}, 32'd1);
      pc_if = 32'h10;
      #1;
      chk("arst_tbl_10", {30'b0, state_if}, 32'd1);
      pc_if = 32'h14;
      #1;
      chk("arst_tbl_14", {30'b0, state_if}, 32'd1);
      rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
